// File: rtl/axi_mem_wr_ctrl.sv
// AXI write-channel controller feeding the internal-memory arbiter.
// Accepts one AW burst at a time, requests the memory write port, streams
// W beats with per-beat addresses, pulses write_done and returns B.
// Optional build macro: MEM_WR_4K_CHK_EN flags INCR bursts crossing 4 KB.
module axi_mem_wr_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     AWID,
    input  logic [31:0]         AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic                waddr_ready,
    output logic                waddr_valid,
    output logic [31:0]         waddr_out,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                write_done
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned MAX_SIZE = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic              err_q;
    logic              aw_ready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic              done_q;

    logic              w_ready_c;
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              last_beat_c;
    logic              aw_err_c;
    logic [31:0]       addr_nxt_c;

    assign aw_hs_c     = AWVALID & aw_ready_q & (state_q == S_IDLE);
    assign w_hs_c      = WVALID & w_ready_c;
    assign last_beat_c = (beat_q == len_q);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and combinational handshake outputs
    always_comb begin
        state_d   = state_q;
        w_ready_c = 1'b0;
        case (state_q)
            S_IDLE: if (aw_hs_c) state_d = S_REQ;
            S_REQ:  if (waddr_ready) state_d = S_DATA;
            S_DATA: begin
                w_ready_c = waddr_ready;
                if (WVALID && waddr_ready && last_beat_c) state_d = S_RESP;
            end
            S_RESP: if (bvalid_q && BREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst legality checks evaluated on the incoming AW request
`ifdef MEM_WR_4K_CHK_EN
    logic [32:0] aw_end_c;
    assign aw_end_c = {1'b0, AWADDR} + ((33'(AWLEN) + 33'd1) << AWSIZE) - 33'd1;
`endif
    always_comb begin
        aw_err_c = 1'b0;
        if (32'(AWSIZE) > MAX_SIZE) aw_err_c = 1'b1;
        if (AWBURST == 2'b11) aw_err_c = 1'b1;
        if (AWBURST == 2'b10 && !(AWLEN == 8'd1 || AWLEN == 8'd3 ||
                                  AWLEN == 8'd7 || AWLEN == 8'd15)) aw_err_c = 1'b1;
`ifdef MEM_WR_4K_CHK_EN
        if (AWBURST[0] && ({1'b0, AWADDR[31:12]} != aw_end_c[32:12])) aw_err_c = 1'b1;
`endif
    end

    // Address of the beat following the current one
    always_comb begin
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] incr;
        step = 32'd1 << size_q;
        mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
        incr = addr_q + step;
        case (burst_q)
            2'b00:   addr_nxt_c = addr_q;
            2'b10:   addr_nxt_c = (addr_q & ~mask) | (incr & mask);
            default: addr_nxt_c = incr;
        endcase
    end

    // Burst context, beat tracking and registered response outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            bid_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            aw_ready_q <= (state_d == S_IDLE);
            done_q     <= 1'b0;
            if (aw_hs_c) begin
                id_q    <= AWID;
                addr_q  <= AWADDR;
                len_q   <= AWLEN;
                size_q  <= AWSIZE;
                burst_q <= (AWBURST == 2'b11) ? 2'b01 : AWBURST;
                beat_q  <= '0;
                err_q   <= aw_err_c;
            end
            if (w_hs_c) begin
                beat_q <= 8'(beat_q + 8'd1);
                addr_q <= addr_nxt_c;
                if (last_beat_c) begin
                    err_q    <= err_q | ~WLAST;
                    bresp_q  <= (err_q | ~WLAST) ? 2'b10 : 2'b00;
                    bid_q    <= id_q;
                    bvalid_q <= 1'b1;
                    done_q   <= 1'b1;
                end else if (WLAST) begin
                    err_q <= 1'b1;
                end
            end
            if (bvalid_q && BREADY) bvalid_q <= 1'b0;
        end
    end

    assign AWREADY     = aw_ready_q;
    assign WREADY      = w_ready_c;
    assign BVALID      = bvalid_q;
    assign BRESP       = bresp_q;
    assign BID         = bid_q;
    assign write_done  = done_q;
    assign waddr_valid = w_hs_c & ~err_q;
    assign waddr_out   = addr_q;
    assign mem_wdata   = WDATA;
    assign mem_be      = waddr_valid ? WSTRB : '0;

endmodule

// File: tb/tb_axi_mem_wr_ctrl.sv
// Scoreboard bench for axi_mem_wr_ctrl: stimulus pushes expected memory
// writes and B responses; a monitor branch pops and compares them.
module tb_axi_mem_wr_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic        waddr_ready, waddr_valid;
    logic [31:0] waddr_out;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        write_done;

    axi_mem_wr_ctrl #(.DATA_W(32), .ID_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .BREADY(BREADY), .waddr_ready(waddr_ready), .waddr_valid(waddr_valid),
        .waddr_out(waddr_out), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .write_done(write_done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t        exp_wr[$];
    logic [5:0] exp_b[$];
    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.a = a; e.d = d; e.be = be;
        exp_wr.push_back(e);
    endtask

    task automatic exp_resp(input logic [3:0] id, input logic [1:0] resp);
        exp_b.push_back({id, resp});
        exp_done++;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && n < 40) begin @(negedge ACLK); n++; end
        if (!AWREADY) chk("aw_timeout", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] be, input logic last);
        int n = 0;
        WDATA = d; WSTRB = be; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 40) begin @(negedge ACLK); n++; end
        if (!WREADY) chk("w_timeout", 32'(WREADY), 32'd1);
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!AWREADY && n < 40) begin @(negedge ACLK); n++; end
        if (!AWREADY) chk("idle_timeout", 32'(AWREADY), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_wready", 32'(WREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_bid", 32'(BID), 32'd0);
        chk("rst_waddr_valid", 32'(waddr_valid), 32'd0);
        chk("rst_waddr_out", waddr_out, 32'd0);
        chk("rst_write_done", 32'(write_done), 32'd0);
    endtask

    initial begin
        ARESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1; waddr_ready = 1'b1;

        fork
            // Monitor: compare every memory write, B handshake and write_done pulse
            begin
                logic prev_done;
                prev_done = 1'b0;
                forever begin
                    @(negedge ACLK);
                    if (waddr_valid) begin
                        if (exp_wr.size() == 0) begin
                            chk("unexpected_write", waddr_out, 32'hFFFF_FFFF);
                        end else begin
                            wr_t e;
                            e = exp_wr.pop_front();
                            chk("wr_addr", waddr_out, e.a);
                            chk("wr_data", mem_wdata, e.d);
                            chk("wr_be", 32'(mem_be), 32'(e.be));
                        end
                    end
                    if (BVALID && BREADY) begin
                        if (exp_b.size() == 0) begin
                            chk("unexpected_b", 32'({BID, BRESP}), 32'hFFFF_FFFF);
                        end else begin
                            logic [5:0] b;
                            b = exp_b.pop_front();
                            chk("b_id", 32'(BID), 32'(b[5:2]));
                            chk("b_resp", 32'(BRESP), 32'(b[1:0]));
                        end
                    end
                    if (write_done) begin
                        done_seen++;
                        chk("write_done_with_bvalid", 32'(BVALID), 32'd1);
                        chk("write_done_width", 32'(prev_done), 32'd0);
                    end
                    prev_done = write_done;
                end
            end
        join_none

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_vals();
        #4 ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_after_reset", 32'(AWREADY), 32'd1);

        // Single beat
        exp_write(32'h100, 32'hDEADBEEF, 4'hF);
        exp_resp(4'd1, 2'b00);
        do_aw(4'd1, 32'h100, 8'd0, 3'd2, 2'b01);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        wait_idle();

        // INCR burst with a two-cycle grant drop after beat 2
        exp_write(32'h200, 32'h11111111, 4'hF);
        exp_write(32'h204, 32'h22222222, 4'h3);
        exp_write(32'h208, 32'h33333333, 4'hC);
        exp_write(32'h20C, 32'h44444444, 4'hF);
        exp_resp(4'd2, 2'b00);
        do_aw(4'd2, 32'h200, 8'd3, 3'd2, 2'b01);
        send_w(32'h11111111, 4'hF, 1'b0);
        send_w(32'h22222222, 4'h3, 1'b0);
        waddr_ready = 1'b0;
        WDATA = 32'h33333333; WSTRB = 4'hC; WVALID = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            chk("drop_wready", 32'(WREADY), 32'd0);
            chk("drop_waddr_valid", 32'(waddr_valid), 32'd0);
        end
        @(posedge ACLK); #1;
        waddr_ready = 1'b1;
        send_w(32'h33333333, 4'hC, 1'b0);
        send_w(32'h44444444, 4'hF, 1'b1);
        wait_idle();

        // WRAP burst
        exp_write(32'h1C, 32'hA0, 4'hF);
        exp_write(32'h10, 32'hA1, 4'hF);
        exp_write(32'h14, 32'hA2, 4'hF);
        exp_write(32'h18, 32'hA3, 4'hF);
        exp_resp(4'd3, 2'b00);
        do_aw(4'd3, 32'h1C, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), 4'hF, i == 3);
        wait_idle();

        // Oversized beat: no writes, SLVERR
        exp_resp(4'd4, 2'b10);
        do_aw(4'd4, 32'h400, 8'd0, 3'd3, 2'b01);
        send_w(32'hBAD0, 4'hF, 1'b1);
        wait_idle();

        // Early WLAST on beat 0 of 2; beat 0 writes before the flag registers
        exp_write(32'h500, 32'h5050, 4'hF);
        exp_resp(4'd5, 2'b10);
        do_aw(4'd5, 32'h500, 8'd1, 3'd2, 2'b01);
        send_w(32'h5050, 4'hF, 1'b1);
        send_w(32'h5151, 4'hF, 1'b0);
        wait_idle();

        // INCR burst crossing 4 KB
`ifdef MEM_WR_4K_CHK_EN
        exp_resp(4'd6, 2'b10);
`else
        exp_write(32'hFF8, 32'hC0, 4'hF);
        exp_write(32'hFFC, 32'hC1, 4'hF);
        exp_write(32'h1000, 32'hC2, 4'hF);
        exp_write(32'h1004, 32'hC3, 4'hF);
        exp_resp(4'd6, 2'b00);
`endif
        do_aw(4'd6, 32'hFF8, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hC0 + 32'(i), 4'hF, i == 3);
        wait_idle();

        // FIXED burst
        exp_write(32'h40, 32'h70, 4'h1);
        exp_write(32'h40, 32'h71, 4'h8);
        exp_resp(4'd7, 2'b00);
        do_aw(4'd7, 32'h40, 8'd1, 3'd2, 2'b00);
        send_w(32'h70, 4'h1, 1'b0);
        send_w(32'h71, 4'h8, 1'b1);
        wait_idle();

        // B backpressure for 5 cycles
        exp_write(32'h80, 32'h8888, 4'hF);
        exp_resp(4'd8, 2'b00);
        BREADY = 1'b0;
        do_aw(4'd8, 32'h80, 8'd0, 3'd2, 2'b01);
        send_w(32'h8888, 4'hF, 1'b1);
        begin
            int n = 0;
            while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
        end
        repeat (5) begin
            @(negedge ACLK);
            chk("hold_bvalid", 32'(BVALID), 32'd1);
            chk("hold_bid", 32'(BID), 32'd8);
            chk("hold_bresp", 32'(BRESP), 32'd0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        wait_idle();

        // Reset during beat 2 of 4: burst discarded
        exp_write(32'h300, 32'h90, 4'hF);
        exp_write(32'h304, 32'h91, 4'hF);
        exp_write(32'h308, 32'h92, 4'hF);
        do_aw(4'd9, 32'h300, 8'd3, 3'd2, 2'b01);
        send_w(32'h90, 4'hF, 1'b0);
        send_w(32'h91, 4'hF, 1'b0);
        WDATA = 32'h92; WSTRB = 4'hF; WVALID = 1'b1;
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_vals();
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        WVALID = 1'b0;
        @(negedge ACLK);
        chk("awready_low_first_cycle", 32'(AWREADY), 32'd0);
        @(negedge ACLK);
        chk("awready_after_mid_reset", 32'(AWREADY), 32'd1);

        repeat (5) @(negedge ACLK);
        chk("writes_left", 32'(exp_wr.size()), 32'd0);
        chk("resps_left", 32'(exp_b.size()), 32'd0);
        chk("write_done_count", 32'(done_seen), 32'(exp_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
